// File: rtl/forward_hazard_ctrl.sv
// Forwarding selects and stall/bubble control for a 5-stage pipeline with
// a compare-in-ID branch unit and a fixed-latency multi-cycle multiplier.
module forward_hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int MUL_LAT  = 4,
    parameter int BR_IN_ID = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_branch,
    input  logic              id_mul,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [ADDR_W-1:0] ex_rs1,
    input  logic [ADDR_W-1:0] ex_rs2,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        fwd_c,
    output logic [1:0]        fwd_d,
    output logic              stall,
    output logic              bubble,
    output logic              mul_busy
);

    localparam int                CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam bit                BR_EN    = (BR_IN_ID != 0);

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   pend_rd_q;

    logic load_use_haz, branch_haz, mul_haz;

    // Operand select: MEM beats WB; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] rs,
        input logic              mem_ok,
        input logic [ADDR_W-1:0] m_rd,
        input logic              m_we,
        input logic [ADDR_W-1:0] w_rd,
        input logic              w_we
    );
        if (mem_ok && m_we && (m_rd != '0) && (m_rd == rs))
            return 2'b01;
        else if (w_we && (w_rd != '0) && (w_rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // True when a non-zero destination matches a source the ID instruction reads.
    function automatic logic id_src_hit(
        input logic [ADDR_W-1:0] rd,
        input logic [ADDR_W-1:0] rs1,
        input logic              use1,
        input logic [ADDR_W-1:0] rs2,
        input logic              use2
    );
        return (rd != '0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs1, 1'b1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b = fwd_sel(ex_rs2, 1'b1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_c = 2'b00;
        fwd_d = 2'b00;
        // A load still in MEM has no data yet, so the compare can only take WB.
        if (BR_EN) begin
            fwd_c = fwd_sel(id_rs1, !mem_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
            fwd_d = fwd_sel(id_rs2, !mem_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        end
    end

    always_comb begin
        load_use_haz = id_valid && ex_memread && ex_regwrite &&
                       id_src_hit(ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

        branch_haz = 1'b0;
        if (BR_EN && id_valid && id_branch)
            branch_haz = (ex_regwrite &&
                          id_src_hit(ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2)) ||
                         (mem_memread &&
                          id_src_hit(mem_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2));

        mul_haz = (state_q == MUL_BUSY) && id_valid &&
                  (id_mul || id_src_hit(pend_rd_q, id_rs1, id_use_rs1, id_rs2, id_use_rs2));
    end

    assign stall    = load_use_haz || branch_haz || mul_haz;
    assign bubble   = stall;
    assign mul_busy = (state_q == MUL_BUSY);

    // Multiplier occupancy: MUL_LAT busy cycles per issued multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_rd_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (id_valid && id_mul && !stall) begin
                        state_q   <= MUL_BUSY;
                        cnt_q     <= CNT_INIT;
                        pend_rd_q <= id_rd;
                    end
                end
                MUL_BUSY: begin
                    if (cnt_q == '0)
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
